term_ctrl: RTL and testbench

//  Text-terminal controller between the keyboard path and the character video memory.
//  - Accepts ASCII characters over a valid/ready handshake.
//  - Sequences writes into the vmem character array; owns cursor position and hardware scroll offset.
//  - Clears the screen after reset and clears the new bottom line on scroll.
//  - The VGA/rom side reads scroll_base and cur_* for display and cursor rendering.

---
 rtl/term_pkg.sv | 28 ++
 rtl/term_blink.sv | 33 +++
 rtl/term_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_term_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared types and constants for the text-terminal controller.
package term_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      EXEC  = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] BS    = 8'h08;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] CR    = 8'h0D;

   localparam int DEF_COLS = 70;
   localparam int DEF_ROWS = 30;

   // Port widths for the column and row buses.
   localparam int X_W = 7;
   localparam int Y_W = 5;

   // Visible ASCII range that gets written to the screen.
   function automatic logic is_print(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/term_blink.sv
// Cursor blink generator: toggles cur_on every BLINK_CYCLES clocks,
// restart forces the cursor visible and restarts the half-period.
module term_blink #(
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic cur_on
);

   localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Half-period counter; phase flips on wrap, a typed char shows the cursor at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         cur_on <= 1'b1;
      end else if (restart) begin
         cnt    <= '0;
         cur_on <= 1'b1;
      end else if (cnt == CNT_MAX) begin
         cnt    <= '0;
         cur_on <= ~cur_on;
      end else begin
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/term_ctrl.sv
// Text-terminal controller: accepts ASCII characters, writes the character
// video memory, keeps the cursor and the hardware scroll offset.
module term_ctrl
   import term_pkg::*;
#(
   parameter int COLS         = DEF_COLS,
   parameter int ROWS         = DEF_ROWS,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           ch_valid,
   input  logic [7:0]     ch_data,
   output logic           ch_ready,
   output logic           wr_en,
   output logic [X_W-1:0] wr_x,
   output logic [Y_W-1:0] wr_y,
   output logic [7:0]     wr_data,
   output logic [Y_W-1:0] scroll_base,
   output logic [X_W-1:0] cur_x,
   output logic [Y_W-1:0] cur_y,
   output logic           cur_on
);

   localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

   state_t         state_q, state_nx;
   logic [7:0]     ch_q, ch_nx;
   logic           wr_en_nx;
   logic [X_W-1:0] wr_x_nx, cur_x_nx;
   logic [Y_W-1:0] wr_y_nx, cur_y_nx, sb_nx;
   logic [7:0]     wr_data_nx;
   logic           accept;
   logic           newline;

   // Logical row to physical vmem row; the 6-bit sum cannot overflow.
   function automatic logic [Y_W-1:0] phys(input logic [Y_W-1:0] r,
                                           input logic [Y_W-1:0] base);
      logic [Y_W:0] s;
      s = {1'b0, r} + {1'b0, base};
      if (s >= (Y_W + 1)'(ROWS)) s = s - (Y_W + 1)'(ROWS);
      return s[Y_W-1:0];
   endfunction

   assign ch_ready = (state_q == IDLE);
   assign accept   = ch_valid && ch_ready;
   // Line feed, or a printable char landing in the last column.
   assign newline  = (ch_q == LF) || (is_print(ch_q) && (cur_x == X_LAST));

   // Next-state, write-port and cursor/scroll decode.
   always_comb begin
      state_nx   = state_q;
      ch_nx      = ch_q;
      wr_en_nx   = 1'b0;
      wr_x_nx    = wr_x;
      wr_y_nx    = wr_y;
      wr_data_nx = wr_data;
      cur_x_nx   = cur_x;
      cur_y_nx   = cur_y;
      sb_nx      = scroll_base;
      case (state_q)
         INIT: begin
            // wr_en is low only on the first INIT cycle after reset.
            if (!wr_en) begin
               wr_en_nx   = 1'b1;
               wr_x_nx    = '0;
               wr_y_nx    = '0;
               wr_data_nx = SPACE;
            end else if ((wr_x == X_LAST) && (wr_y == Y_LAST)) begin
               state_nx = IDLE;
            end else begin
               wr_en_nx = 1'b1;
               if (wr_x == X_LAST) begin
                  wr_x_nx = '0;
                  wr_y_nx = wr_y + 1'b1;
               end else begin
                  wr_x_nx = wr_x + 1'b1;
               end
            end
         end
         IDLE: begin
            // The cell write is issued here so it is visible during EXEC.
            if (ch_valid) begin
               ch_nx    = ch_data;
               state_nx = EXEC;
               if (is_print(ch_data)) begin
                  wr_en_nx   = 1'b1;
                  wr_x_nx    = cur_x;
                  wr_y_nx    = phys(cur_y, scroll_base);
                  wr_data_nx = ch_data;
               end else if (ch_data == BS) begin
                  if (cur_x != '0) begin
                     wr_en_nx   = 1'b1;
                     wr_x_nx    = cur_x - 1'b1;
                     wr_y_nx    = phys(cur_y, scroll_base);
                     wr_data_nx = SPACE;
                  end else if (cur_y != '0) begin
                     wr_en_nx   = 1'b1;
                     wr_x_nx    = X_LAST;
                     wr_y_nx    = phys(cur_y - 1'b1, scroll_base);
                     wr_data_nx = SPACE;
                  end
               end
            end
         end
         EXEC: begin
            state_nx = IDLE;
            if (newline) begin
               cur_x_nx = '0;
               if (cur_y != Y_LAST) begin
                  cur_y_nx = cur_y + 1'b1;
               end else begin
                  // Scroll: the old top row becomes the new bottom row and is blanked.
                  sb_nx      = (scroll_base == Y_LAST) ? '0 : scroll_base + 1'b1;
                  state_nx   = CLEAR;
                  wr_en_nx   = 1'b1;
                  wr_x_nx    = '0;
                  wr_y_nx    = scroll_base;
                  wr_data_nx = SPACE;
               end
            end else if (is_print(ch_q)) begin
               cur_x_nx = cur_x + 1'b1;
            end else if (ch_q == CR) begin
               cur_x_nx = '0;
            end else if (ch_q == BS) begin
               if (cur_x != '0) begin
                  cur_x_nx = cur_x - 1'b1;
               end else if (cur_y != '0) begin
                  cur_x_nx = X_LAST;
                  cur_y_nx = cur_y - 1'b1;
               end
            end
         end
         CLEAR: begin
            if (wr_x == X_LAST) begin
               state_nx = IDLE;
            end else begin
               wr_en_nx = 1'b1;
               wr_x_nx  = wr_x + 1'b1;
            end
         end
         default: state_nx = INIT;
      endcase
   end

   // State, write port, cursor and scroll registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= INIT;
         ch_q        <= '0;
         wr_en       <= 1'b0;
         wr_x        <= '0;
         wr_y        <= '0;
         wr_data     <= '0;
         cur_x       <= '0;
         cur_y       <= '0;
         scroll_base <= '0;
      end else begin
         state_q     <= state_nx;
         ch_q        <= ch_nx;
         wr_en       <= wr_en_nx;
         wr_x        <= wr_x_nx;
         wr_y        <= wr_y_nx;
         wr_data     <= wr_data_nx;
         cur_x       <= cur_x_nx;
         cur_y       <= cur_y_nx;
         scroll_base <= sb_nx;
      end
   end

   term_blink #(
      .BLINK_CYCLES(BLINK_CYCLES)
   ) u_blink (
      .clock  (clock),
      .reset  (reset),
      .restart(accept),
      .cur_on (cur_on)
   );

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: table of characters with expected cursor state,
// plus sequences for wrap, scroll, backspace across rows and mid-clear reset.
module tb_term_ctrl;
   import term_pkg::*;

   localparam int COLS  = 70;
   localparam int ROWS  = 30;
   localparam int BLINK = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ch_valid = 1'b0;
   logic [7:0] ch_data = 8'h00;
   logic       ch_ready, wr_en, cur_on;
   logic [6:0] wr_x, cur_x;
   logic [4:0] wr_y, cur_y, scroll_base;
   logic [7:0] wr_data;

   term_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK)) dut (
      .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
      .ch_ready(ch_ready), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .scroll_base(scroll_base), .cur_x(cur_x),
      .cur_y(cur_y), .cur_on(cur_on)
   );

   always #5 clock = ~clock;

   typedef struct { int x; int y; int d; } wr_t;
   typedef struct { logic [7:0] ch; int ex; int ey; int esb; int elow; } vec_t;

   wr_t  exq[$];
   wr_t  mon_e;
   vec_t tbl[10];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mx = 0, my = 0, msb = 0;
   int   low;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   function automatic int mphys(input int r);
      int s;
      s = r + msb;
      return (s >= ROWS) ? s - ROWS : s;
   endfunction

   task automatic push_wr(input int x, input int y, input int d);
      wr_t e;
      e.x = x; e.y = y; e.d = d;
      exq.push_back(e);
   endtask

   task automatic model_nl();
      mx = 0;
      if (my < ROWS - 1) my++;
      else begin
         for (int i = 0; i < COLS; i++) push_wr(i, msb, 32);
         msb = (msb + 1) % ROWS;
      end
   endtask

   // Reference behaviour for one accepted character.
   task automatic model_char(input logic [7:0] c);
      if (c >= 8'h20 && c <= 8'h7E) begin
         push_wr(mx, mphys(my), int'(c));
         if (mx < COLS - 1) mx++;
         else model_nl();
      end else if (c == 8'h0A) model_nl();
      else if (c == 8'h0D) mx = 0;
      else if (c == 8'h08) begin
         if (mx > 0) begin
            mx--; push_wr(mx, mphys(my), 32);
         end else if (my > 0) begin
            my--; mx = COLS - 1; push_wr(mx, mphys(my), 32);
         end
      end
   endtask

   // Write monitor: every wr_en pulse pops one expected write.
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         chk("ready_during_write", ch_ready, 0);
         if (exq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: got (%0d,%0d)=%0h, required no write", wr_x, wr_y, wr_data);
         end else begin
            mon_e = exq.pop_front();
            chk("wr_x", wr_x, mon_e.x);
            chk("wr_y", wr_y, mon_e.y);
            chk("wr_data", wr_data, mon_e.d);
         end
      end
   end

   task automatic wait_ready();
      int t;
      t = 0;
      while (ch_ready !== 1'b1 && t < 300) begin @(negedge clock); t++; end
      if (ch_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL ready_timeout: got ch_ready=%0d, required 1", ch_ready);
      end
   endtask

   // Hand one char over; low = cycles ch_ready stays low afterwards.
   task automatic send(input logic [7:0] c, input bit use_model, output int lo);
      wait_ready();
      if (use_model) model_char(c);
      ch_valid = 1'b1;
      ch_data  = c;
      @(posedge clock);
      #1 ch_valid = 1'b0;
      ch_data = 8'($urandom);
      lo = 0;
      @(negedge clock);
      while (ch_ready !== 1'b1 && lo < 200) begin lo++; @(negedge clock); end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ready"}, ch_ready, 0);
      chk({nm, "_wr_en"}, wr_en, 0);
      chk({nm, "_wr_x"}, wr_x, 0);
      chk({nm, "_wr_y"}, wr_y, 0);
      chk({nm, "_wr_data"}, wr_data, 0);
      chk({nm, "_sb"}, scroll_base, 0);
      chk({nm, "_cur_x"}, cur_x, 0);
      chk({nm, "_cur_y"}, cur_y, 0);
      chk({nm, "_cur_on"}, cur_on, 1);
   endtask

   // Count the screen-clear pulses until ch_ready and check the last one.
   task automatic wait_init(input string nm);
      int t, pulses, px, py;
      logic pe;
      t = 0; pulses = 0; px = 0; py = 0; pe = 1'b0;
      @(negedge clock);
      while (ch_ready !== 1'b1 && t < 2300) begin
         pe = wr_en; px = int'(wr_x); py = int'(wr_y);
         if (wr_en === 1'b1) pulses++;
         t++;
         @(negedge clock);
      end
      chk({nm, "_ready"}, ch_ready, 1);
      chk({nm, "_pulses"}, pulses, COLS * ROWS);
      chk({nm, "_last_en"}, pe, 1);
      chk({nm, "_last_x"}, px, COLS - 1);
      chk({nm, "_last_y"}, py, ROWS - 1);
      chk({nm, "_queue"}, exq.size(), 0);
      chk({nm, "_cur_x"}, cur_x, 0);
      chk({nm, "_cur_y"}, cur_y, 0);
      chk({nm, "_sb"}, scroll_base, 0);
   endtask

   task automatic chk_cur(input string nm, input int x, input int y, input int sb);
      chk({nm, "_cur_x"}, cur_x, x);
      chk({nm, "_cur_y"}, cur_y, y);
      chk({nm, "_sb"}, scroll_base, sb);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'h41, 1, 0, 0, 1};
      tbl[1] = '{8'h42, 2, 0, 0, 1};
      tbl[2] = '{8'h0D, 0, 0, 0, 1};
      tbl[3] = '{8'h01, 0, 0, 0, 1};
      tbl[4] = '{8'h08, 0, 0, 0, 1};
      tbl[5] = '{8'h0A, 0, 1, 0, 1};
      tbl[6] = '{8'h78, 1, 1, 0, 1};
      tbl[7] = '{8'h08, 0, 1, 0, 1};
      tbl[8] = '{8'h08, 69, 0, 0, 1};
      tbl[9] = '{8'h71, 0, 1, 0, 1};

      // Power-on reset and screen clear.
      #2 reset = 1'b0;
      #18 chk_reset("rst");
      for (int i = 0; i < COLS * ROWS; i++) push_wr(i % COLS, i / COLS, 32);
      #12 reset = 1'b1;
      wait_init("init");

      // Table of single characters from (0,0).
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].ch, 1'b1, low);
         chk_cur($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].esb);
         chk($sformatf("vec%0d_low", i), low, tbl[i].elow);
         chk($sformatf("vec%0d_queue", i), exq.size(), 0);
      end

      // Blink restart and half-period.
      wait_ready();
      ch_valid = 1'b1; ch_data = 8'h01;
      @(posedge clock);
      #1 ch_valid = 1'b0;
      chk("blink_restart", cur_on, 1);
      repeat (BLINK - 1) @(posedge clock);
      #1 chk("blink_hold", cur_on, 1);
      @(posedge clock);
      #1 chk("blink_off", cur_on, 0);
      repeat (BLINK) @(posedge clock);
      #1 chk("blink_on", cur_on, 1);
      @(negedge clock);

      // Wrap from the last column of row 5.
      for (int i = 0; i < 4; i++) send(8'h0A, 1'b1, low);
      for (int i = 0; i < COLS - 1; i++) send(8'h2E, 1'b1, low);
      chk_cur("at69_5", 69, 5, 0);
      push_wr(69, 5, 8'h5A); mx = 0; my = 6;
      send(8'h5A, 1'b0, low);
      chk_cur("wrap", 0, 6, 0);
      chk("wrap_low", low, 1);
      chk("wrap_queue", exq.size(), 0);

      // Scroll on LF at the bottom row.
      for (int i = 0; i < 23; i++) send(8'h0A, 1'b1, low);
      send(8'h61, 1'b1, low); send(8'h62, 1'b1, low); send(8'h63, 1'b1, low);
      chk_cur("at3_29", 3, 29, 0);
      for (int i = 0; i < COLS; i++) push_wr(i, 0, 32);
      mx = 0; msb = 1;
      send(8'h0A, 1'b0, low);
      chk_cur("scroll", 0, 29, 1);
      chk("scroll_low", low, 71);
      chk("scroll_queue", exq.size(), 0);
      push_wr(0, 0, 8'h43); mx = 1;
      send(8'h43, 1'b0, low);
      chk_cur("after_scroll", 1, 29, 1);
      chk("after_scroll_queue", exq.size(), 0);

      // Backspace up to (0,3), then across the row boundary.
      for (int k = 0; k < 3000 && !(mx == 0 && my == 3); k++) send(8'h08, 1'b1, low);
      chk_cur("at0_3", 0, 3, 1);
      push_wr(69, 3, 32); mx = 69; my = 2;
      send(8'h08, 1'b0, low);
      chk_cur("bs_row", 69, 2, 1);
      chk("bs_row_low", low, 1);
      chk("bs_row_queue", exq.size(), 0);

      // Reset in the middle of a scroll clear.
      for (int i = 0; i < 27; i++) send(8'h0A, 1'b1, low);
      chk_cur("at0_29", 0, 29, 1);
      wait_ready();
      model_char(8'h0A);
      ch_valid = 1'b1; ch_data = 8'h0A;
      @(posedge clock);
      #1 ch_valid = 1'b0;
      repeat (20) @(posedge clock);
      #1 chk("clear_mid_en", wr_en, 1);
      chk("clear_mid_x", wr_x, 19);
      chk("clear_mid_y", wr_y, 1);
      #1 reset = 1'b0;
      #1 chk_reset("midrst");
      exq.delete();
      mx = 0; my = 0; msb = 0;
      for (int i = 0; i < COLS * ROWS; i++) push_wr(i % COLS, i / COLS, 32);
      #10 reset = 1'b1;
      wait_init("reinit");
      send(8'h41, 1'b1, low);
      chk_cur("reinit_a", 1, 0, 0);
      chk("reinit_queue", exq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
